// File: rtl/led_pattern_detector_pkg.sv
// ----------------------------------------------------------------------------
// led_pattern_detector_pkg
// Constants that describe the eight LED patterns. The same values are used by
// the pattern generator, so the detector and the generator agree on what a
// legal frame sequence looks like.
//   - pattern IDs 0..7
//   - knight table, walk base, expand sequence
//   - alternate constants, LFSR taps and seed
//   - small helpers: popcount and LFSR next-state
// ----------------------------------------------------------------------------
package led_pattern_detector_pkg;

   localparam logic [2:0] PAT_KNIGHT  = 3'd0;
   localparam logic [2:0] PAT_WALK    = 3'd1;
   localparam logic [2:0] PAT_EXPAND  = 3'd2;
   localparam logic [2:0] PAT_BLINK   = 3'd3;
   localparam logic [2:0] PAT_ALT     = 3'd4;
   localparam logic [2:0] PAT_MARQUEE = 3'd5;
   localparam logic [2:0] PAT_SPARKLE = 3'd6;
   localparam logic [2:0] PAT_OFF     = 3'd7;

   // Index 0 is the outermost position (81), index 3 the innermost (18).
   localparam logic [3:0][7:0] KNIGHT_TABLE = {8'h18, 8'h24, 8'h42, 8'h81};

   // Walk frames are WALK_BASE shifted left by 0..WALK_STEPS-1.
   localparam logic [7:0] WALK_BASE  = 8'h03;
   localparam int         WALK_STEPS = 7;

   // Expand chain 00-18-3C-7E-FF; a legal move is one step along the chain.
   localparam logic [4:0][7:0] EXPAND_SEQ = {8'hFF, 8'h7E, 8'h3C, 8'h18, 8'h00};

   localparam logic [7:0] ALT_A = 8'hAA;
   localparam logic [7:0] ALT_B = 8'h55;

   localparam int         LFSR_TAP_A = 7;
   localparam int         LFSR_TAP_B = 5;
   localparam int         LFSR_TAP_C = 4;
   localparam int         LFSR_TAP_D = 3;
   localparam logic [7:0] LFSR_SEED  = 8'hAA;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) cnt = cnt + {3'd0, v[i]};
      return cnt;
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
   endfunction

endpackage

// File: rtl/led_pattern_detector_checker.sv
// ----------------------------------------------------------------------------
// led_transition_checker
// Purely combinational. For a pair of successive frames it reports, per
// pattern, whether prev -> frame_in is a legal step of that pattern.
//   prev      in  8  previously accepted frame
//   frame_in  in  8  current frame
//   legal     out 8  bit k set when the step is legal for pattern k
// ----------------------------------------------------------------------------
module led_transition_checker
   import led_pattern_detector_pkg::*;
(
   input  logic [7:0] prev,
   input  logic [7:0] frame_in,
   output logic [7:0] legal
);

   // Position lookups return {hit, index}.
   function automatic logic [3:0] knight_pos(input logic [7:0] f);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < 4; i++) if (f == KNIGHT_TABLE[i]) r = {1'b1, 3'(i)};
      return r;
   endfunction

   function automatic logic [3:0] walk_pos(input logic [7:0] f);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < WALK_STEPS; i++) if (f == 8'(WALK_BASE << i)) r = {1'b1, 3'(i)};
      return r;
   endfunction

   function automatic logic [3:0] expand_pos(input logic [7:0] f);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 0; i < 5; i++) if (f == EXPAND_SEQ[i]) r = {1'b1, 3'(i)};
      return r;
   endfunction

   // Indices are small (max 6), so the +1 never wraps.
   function automatic logic adjacent(input logic [2:0] a, input logic [2:0] b);
      return (a == b + 3'd1) || (b == a + 3'd1);
   endfunction

   logic [3:0] kp, kf, wp, wf, ep, ef;

   assign kp = knight_pos(prev);
   assign kf = knight_pos(frame_in);
   assign wp = walk_pos(prev);
   assign wf = walk_pos(frame_in);
   assign ep = expand_pos(prev);
   assign ef = expand_pos(frame_in);

   always_comb begin
      legal = 8'd0;
      // Knight and walk allow repeats (difference 0); expand needs a real step.
      legal[PAT_KNIGHT]  = kp[3] & kf[3] & ((kp[2:0] == kf[2:0]) | adjacent(kp[2:0], kf[2:0]));
      legal[PAT_WALK]    = wp[3] & wf[3] & ((wp[2:0] == wf[2:0]) | adjacent(wp[2:0], wf[2:0]));
      legal[PAT_EXPAND]  = ep[3] & ef[3] & adjacent(ep[2:0], ef[2:0]);
      legal[PAT_BLINK]   = ((prev == 8'h00) || (prev == 8'hFF)) && (frame_in == ~prev);
      legal[PAT_ALT]     = ((prev == ALT_A) || (prev == ALT_B)) && (frame_in == ~prev);
      legal[PAT_MARQUEE] = (popcount8(prev) == 4'd3) && (frame_in == {prev[6:0], prev[7]});
      legal[PAT_SPARKLE] = (prev != 8'h00) && (frame_in == lfsr_next(prev));
      legal[PAT_OFF]     = (prev == 8'h00) && (frame_in == 8'h00);
   end

endmodule

// File: rtl/led_pattern_detector.sv
// ----------------------------------------------------------------------------
// led_pattern_detector
// Watches the LED pattern bus and identifies which of the eight patterns is
// being shown, with lock/mismatch status and a frame-period measurement.
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          low: strobes ignored, all state (and the period count) holds
//   clear        synchronous clear, same effect as reset; beats a strobe
//   frame_in     observed LED frame, qualified by frame_valid
//   frame_valid  one-cycle strobe; a frame is accepted when
//                frame_valid & ena & ~clear (no back-pressure exists)
//   pat_id       identified pattern
//   locked       pat_id is trustworthy
//   mismatch     one-cycle pulse: locked pattern saw an illegal step
//   period_out   clk cycles between the last two accepted strobes
// ----------------------------------------------------------------------------
module led_pattern_detector
   import led_pattern_detector_pkg::*;
#(
   parameter int LOCK_LEN = 4,
   parameter int RUN_W    = 3,
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                clear,
   input  logic [7:0]          frame_in,
   input  logic                frame_valid,
   output logic [2:0]          pat_id,
   output logic                locked,
   output logic                mismatch,
   output logic [PERIOD_W-1:0] period_out
);

   localparam logic [RUN_W-1:0]    RUN_MAX  = {RUN_W{1'b1}};
   localparam logic [RUN_W-1:0]    LOCK_THR = RUN_W'(LOCK_LEN);
   localparam logic [PERIOD_W-1:0] CNT_MAX  = {PERIOD_W{1'b1}};

   logic [7:0]                prev_q, prev_d;
   logic                      have_prev_q, have_prev_d;
   logic [7:0][RUN_W-1:0]     run_q, run_d;
   logic [PERIOD_W-1:0]       cnt_q, cnt_d;
   logic [PERIOD_W-1:0]       period_q, period_d;
   logic [2:0]                pat_id_q, pat_id_d;
   logic                      locked_q, locked_d;
   logic                      mismatch_q, mismatch_d;

   logic [7:0] legal;
   logic       accept;

   led_transition_checker u_checker (
      .prev     (prev_q),
      .frame_in (frame_in),
      .legal    (legal)
   );

   assign accept = frame_valid & ena & ~clear;

   always_comb begin
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      run_d       = run_q;
      cnt_d       = cnt_q;
      period_d    = period_q;
      pat_id_d    = pat_id_q;
      locked_d    = locked_q;
      mismatch_d  = 1'b0;

      if (clear) begin
         prev_d      = 8'd0;
         have_prev_d = 1'b0;
         run_d       = '0;
         cnt_d       = '0;
         period_d    = '0;
         pat_id_d    = 3'd0;
         locked_d    = 1'b0;
      end else if (accept && !have_prev_q) begin
         // First frame only primes the comparison.
         prev_d      = frame_in;
         have_prev_d = 1'b1;
      end else if (accept) begin
         for (int k = 0; k < 8; k++) begin
            if (!legal[k])             run_d[k] = '0;
            else if (run_q[k] != RUN_MAX) run_d[k] = run_q[k] + 1'b1;
         end
         if (locked_q && !legal[pat_id_q]) begin
            mismatch_d = 1'b1;
            locked_d   = 1'b0;
         end
         // Hysteresis: only search for a candidate when not (still) locked.
         // Descending loop so the lowest qualifying index wins.
         if (!(locked_q && legal[pat_id_q])) begin
            for (int k = 7; k >= 0; k--) begin
               if (run_d[k] >= LOCK_THR) begin
                  pat_id_d = 3'(k);
                  locked_d = 1'b1;
               end
            end
         end
         period_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
         cnt_d    = '0;
         prev_d   = frame_in;
      end else if (ena && have_prev_q && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q      <= 8'd0;
         have_prev_q <= 1'b0;
         run_q       <= '0;
         cnt_q       <= '0;
         period_q    <= '0;
         pat_id_q    <= 3'd0;
         locked_q    <= 1'b0;
         mismatch_q  <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
         run_q       <= run_d;
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         pat_id_q    <= pat_id_d;
         locked_q    <= locked_d;
         mismatch_q  <= mismatch_d;
      end
   end

   assign pat_id     = pat_id_q;
   assign locked     = locked_q;
   assign mismatch   = mismatch_q;
   assign period_out = period_q;

endmodule

// File: tb/tb_led_pattern_detector.sv
// ----------------------------------------------------------------------------
// tb_led_pattern_detector
// Directed scenarios followed by randomized pattern traffic, every cycle
// compared against a behavioural model built from the pattern rules.
// ----------------------------------------------------------------------------
module tb_led_pattern_detector;

   localparam int LOCK_LEN = 4;
   localparam int RUN_MAX  = 7;
   localparam int CNT_MAX  = 65535;

   logic        clk = 1'b0;
   logic        rst_n, ena, clear, frame_valid;
   logic [7:0]  frame_in;
   logic [2:0]  pat_id;
   logic        locked, mismatch;
   logic [15:0] period_out;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   led_pattern_detector #(.LOCK_LEN(4), .RUN_W(3), .PERIOD_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .clear       (clear),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .pat_id      (pat_id),
      .locked      (locked),
      .mismatch    (mismatch),
      .period_out  (period_out)
   );

   // ---------------- reference tables ----------------
   logic [7:0]  knight_tab [4] = '{8'h81, 8'h42, 8'h24, 8'h18};
   logic [15:0] expand_pairs [8] = '{16'h183C, 16'h1800, 16'h3C7E, 16'h3C18,
                                     16'h7EFF, 16'h7E3C, 16'hFF7E, 16'h0018};
   logic [7:0]  seed_tab [8] = '{8'h81, 8'h03, 8'h18, 8'hFF, 8'hAA, 8'h07, 8'hAA, 8'h00};

   function automatic int knight_idx(input logic [7:0] v);
      for (int i = 0; i < 4; i++) if (knight_tab[i] == v) return i;
      return -1;
   endfunction

   function automatic int walk_idx(input logic [7:0] v);
      logic [7:0] w;
      for (int i = 0; i < 7; i++) begin
         w = 8'h03;
         w = w << i;
         if (w == v) return i;
      end
      return -1;
   endfunction

   function automatic logic [7:0] ref_legal(input logic [7:0] p, input logic [7:0] f);
      logic [7:0] r;
      int a, b;
      r = 8'd0;
      a = knight_idx(p); b = knight_idx(f);
      if (a >= 0 && b >= 0 && a - b <= 1 && b - a <= 1) r[0] = 1'b1;
      a = walk_idx(p); b = walk_idx(f);
      if (a >= 0 && b >= 0 && a - b <= 1 && b - a <= 1) r[1] = 1'b1;
      for (int i = 0; i < 8; i++) if (expand_pairs[i] == {p, f}) r[2] = 1'b1;
      r[3] = (p == 8'h00 || p == 8'hFF) && (f == ~p);
      r[4] = (p == 8'hAA || p == 8'h55) && (f == ~p);
      r[5] = ($countones(p) == 3) && (f == {p[6:0], p[7]});
      r[6] = (p != 8'h00) && (f == {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]});
      r[7] = (p == 8'h00) && (f == 8'h00);
      return r;
   endfunction

   // ---------------- behavioural model ----------------
   logic [7:0] m_prev;
   bit         m_have, m_locked, m_mis;
   int         m_run [8];
   int         m_pat, m_cnt, m_period;

   task automatic model_reset();
      m_prev = 8'h00; m_have = 0; m_locked = 0; m_mis = 0;
      m_pat = 0; m_cnt = 0; m_period = 0;
      for (int k = 0; k < 8; k++) m_run[k] = 0;
   endtask

   task automatic model_edge(input bit v, input logic [7:0] f, input bit e, input bit c);
      logic [7:0] lg;
      m_mis = 0;
      if (c) begin
         model_reset();
      end else if (e) begin
         if (v && !m_have) begin
            m_prev = f; m_have = 1;
         end else if (v) begin
            lg = ref_legal(m_prev, f);
            for (int k = 0; k < 8; k++)
               m_run[k] = lg[k] ? ((m_run[k] < RUN_MAX) ? m_run[k] + 1 : RUN_MAX) : 0;
            if (m_locked && !lg[m_pat]) begin
               m_mis = 1; m_locked = 0;
            end
            if (!m_locked)
               for (int k = 0; k < 8; k++)
                  if (!m_locked && m_run[k] >= LOCK_LEN) begin
                     m_pat = k; m_locked = 1;
                  end
            m_period = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
            m_cnt = 0;
            m_prev = f;
         end else if (m_have && m_cnt < CNT_MAX) begin
            m_cnt++;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".pat_id"},     pat_id,     m_pat);
      check({tag, ".locked"},     locked,     m_locked);
      check({tag, ".mismatch"},   mismatch,   m_mis);
      check({tag, ".period_out"}, period_out, m_period);
   endtask

   // ---------------- drivers ----------------
   task automatic cycle(input bit v, input logic [7:0] f, input bit e, input bit c);
      frame_valid = v;
      frame_in    = v ? f : 8'($urandom_range(0, 255));
      ena         = e;
      clear       = c;
      @(posedge clk);
      model_edge(v, f, e, c);
      #1;
      check_outputs("cyc");
   endtask

   task automatic strobe(input logic [7:0] f, input int gap);
      cycle(1'b1, f, 1'b1, 1'b0);
      for (int i = 1; i < gap; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic do_clear();
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
   endtask

   initial begin
      logic [7:0] marquee [5] = '{8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70};
      logic [7:0] knight  [5] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18};
      logic [7:0] last, f;
      int         cur_pat, r;
      int         cands [$];

      rst_n = 1'b0; ena = 1'b0; clear = 1'b0; frame_valid = 1'b0; frame_in = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset.pat_id", pat_id, 0);
      check("reset.locked", locked, 0);
      check("reset.mismatch", mismatch, 0);
      check("reset.period", period_out, 0);
      rst_n = 1'b1;

      // Marquee, strobes 8 cycles apart.
      for (int i = 0; i < 4; i++) strobe(marquee[i], 8);
      check("marquee.prelock", locked, 0);
      strobe(marquee[4], 8);
      check("marquee.locked", locked, 1);
      check("marquee.pat_id", pat_id, 5);
      check("marquee.period", period_out, 8);

      // Knight, including a repeated end frame and the bounce back.
      do_clear();
      for (int i = 0; i < 5; i++) strobe(knight[i], 3);
      check("knight.locked", locked, 1);
      check("knight.pat_id", pat_id, 0);
      check("knight.period", period_out, 3);
      cycle(1'b1, 8'h24, 1'b1, 1'b0);
      check("knight.bounce_mis", mismatch, 0);
      check("knight.bounce_lock", locked, 1);

      // Blink.
      do_clear();
      for (int i = 0; i < 5; i++) strobe((i % 2) ? 8'h00 : 8'hFF, 2);
      check("blink.pat_id", pat_id, 3);
      check("blink.locked", locked, 1);

      // Alternate, then an illegal frame.
      do_clear();
      for (int i = 0; i < 5; i++) strobe((i % 2) ? 8'h55 : 8'hAA, 2);
      check("alt.pat_id", pat_id, 4);
      check("alt.locked", locked, 1);
      cycle(1'b1, 8'h0F, 1'b1, 1'b0);
      check("alt.mis_pulse", mismatch, 1);
      check("alt.unlocked", locked, 0);
      check("alt.pat_hold", pat_id, 4);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("alt.mis_end", mismatch, 0);

      // Clear coinciding with a strobe while locked.
      do_clear();
      for (int i = 0; i < 5; i++) strobe((i % 2) ? 8'h55 : 8'hAA, 2);
      check("clr.prelocked", locked, 1);
      cycle(1'b1, 8'h55, 1'b1, 1'b1);
      check("clr.pat_id", pat_id, 0);
      check("clr.locked", locked, 0);
      check("clr.period", period_out, 0);
      for (int i = 0; i < 4; i++) strobe((i % 2) ? 8'hAA : 8'h55, 2);
      check("clr.not_yet", locked, 0);
      strobe(8'h55, 2);
      check("clr.relock", locked, 1);
      check("clr.relock_pat", pat_id, 4);

      // ena low: strobes ignored, period counter frozen.
      for (int i = 0; i < 10; i++) cycle(1'b1, (i % 2) ? 8'h42 : 8'h81, 1'b0, 1'b0);
      check("ena.pat_id", pat_id, 4);
      check("ena.locked", locked, 1);
      check("ena.period", period_out, 2);
      strobe(8'hAA, 2);
      check("ena.period_frozen", period_out, 2);
      check("ena.still_locked", locked, 1);

      // Asynchronous reset in the middle of a locked run.
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("areset.pat_id", pat_id, 0);
      check("areset.locked", locked, 0);
      check("areset.period", period_out, 0);
      #3 rst_n = 1'b1;

      // Randomized pattern traffic with noise, switches, ena gaps and clears.
      cur_pat = 0;
      last    = 8'h00;
      for (int n = 0; n < 2500; n++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            do_clear();
         end else if (r < 6) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
         end else if (r < 45) begin
            if ($urandom_range(0, 24) == 0) cur_pat = $urandom_range(0, 7);
            if ($urandom_range(0, 11) == 0) begin
               f = 8'($urandom_range(0, 255));
            end else begin
               cands.delete();
               for (int c = 0; c < 256; c++)
                  if (ref_legal(last, 8'(c)) & (8'h01 << cur_pat)) cands.push_back(c);
               if (cands.size() == 0) f = seed_tab[cur_pat];
               else f = 8'(cands[$urandom_range(0, cands.size() - 1)]);
            end
            cycle(1'b1, f, 1'b1, 1'b0);
            last = f;
         end else begin
            cycle(1'b0, 8'h00, ($urandom_range(0, 9) != 0), 1'b0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
